// File: rtl/clk_src_ctrl.sv
// -----------------------------------------------------------------------------
// clk_src_ctrl
//
// Sequenced N-way CPU clock-source controller. Runs entirely on the
// free-running sys_clock and drives one-hot enables for the global clock
// buffers feeding clk_cpu. Every source change goes through
// RUN -> GATE -> WAIT_LOCK -> ENABLE -> RUN: all enables are dropped for
// GAP_CYCLES, the target's synchronised lock must then stay high for
// SETTLE_CYCLES consecutive cycles (or TIMEOUT_CYCLES expire, in which case
// DEFAULT_SRC is used instead), and only then is the target enabled. The CPU
// is held in reset whenever no qualified source is active.
//
// Optional feature (macro CLK_SRC_LOCK_FALLBACK_EN):
//   defined   - lock loss on the active source in RUN automatically starts a
//               switch to DEFAULT_SRC and pulses switch_err.
//   undefined - lock loss only drops locked / raises cpu_reset; the source
//               stays enabled and recovery follows the lock.
//
// Ports:
//   sys_clock_i   in   1        controller clock, always running
//   reset_i       in   1        synchronous, active-high
//   sel_req_i     in   SEL_W    requested source index
//   sel_valid_i   in   1        request strobe, accepted when sel_ready_o
//   sel_ready_o   out  1        high only in RUN
//   src_locked_i  in   NUM_SRC  per-source lock, asynchronous
//   clk_en_o      out  NUM_SRC  one-hot or all-zero buffer enables
//   sel_active_o  out  SEL_W    index of the currently enabled source
//   locked_o      out  1        enabled source present and synced-locked
//   cpu_reset_o   out  1        registered inverse of locked_o
//   switch_err_o  out  1        one-cycle pulse: rejected request or timeout
// -----------------------------------------------------------------------------
module clk_src_ctrl #(
  parameter int                 NUM_SRC        = 4,
  parameter int                 SEL_W          = 2,
  parameter int                 DEFAULT_SRC    = 0,
  parameter logic [NUM_SRC-1:0] ALWAYS_LOCKED  = {{(NUM_SRC-1){1'b0}}, 1'b1},
  parameter int                 GAP_CYCLES     = 8,
  parameter int                 SETTLE_CYCLES  = 1024,
  parameter int                 TIMEOUT_CYCLES = 65536
) (
  input  logic               sys_clock_i,
  input  logic               reset_i,
  input  logic [SEL_W-1:0]   sel_req_i,
  input  logic               sel_valid_i,
  output logic               sel_ready_o,
  input  logic [NUM_SRC-1:0] src_locked_i,
  output logic [NUM_SRC-1:0] clk_en_o,
  output logic [SEL_W-1:0]   sel_active_o,
  output logic               locked_o,
  output logic               cpu_reset_o,
  output logic               switch_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IDX_N = 1 << SEL_W;

  localparam logic [SEL_W-1:0] DEF_SEL    = SEL_W'(DEFAULT_SRC);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_TGT = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_GATE,
    ST_WAIT_LOCK,
    ST_ENABLE
  } state_e;

  state_e             state_q;
  logic [SEL_W-1:0]   target_q;
  logic [CNT_W-1:0]   cnt_q;      // gap length in GATE, timeout in WAIT_LOCK
  logic [CNT_W-1:0]   settle_q;
  logic [NUM_SRC-1:0] clk_en_q;
  logic [SEL_W-1:0]   sel_active_q;
  logic               locked_q;
  logic               cpu_reset_q;
  logic               switch_err_q;
  logic [NUM_SRC-1:0] sync1_q;
  logic [NUM_SRC-1:0] sync2_q;

  // Lock vector widened to every encodable index, so out-of-range
  // indices read as unlocked instead of indexing past the vector.
  logic [IDX_N-1:0]   lk_ext;
  logic               lk_active;
  logic               lk_target;

  logic [CNT_W-1:0]   settle_d;
  logic               start_d;
  logic [SEL_W-1:0]   target_d;
  logic               err_d;

  function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_SRC-1:0] oh;
    for (int i = 0; i < NUM_SRC; i++) begin
      oh[i] = (idx == SEL_W'(i));
    end
    return oh;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Two-flop synchroniser for the asynchronous lock inputs.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours, which is what makes this a 2-stage
  // chain instead of a single wire.
  always_ff @(posedge sys_clock_i) begin
    if (reset_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src_locked_i;
      sync2_q <= sync1_q;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value held over and no latch is inferred.
  always_comb begin
    lk_ext                = '0;
    lk_ext[NUM_SRC-1:0]   = ALWAYS_LOCKED | sync2_q;
    lk_active             = lk_ext[sel_active_q];
    lk_target             = lk_ext[target_q];
    settle_d              = lk_target ? sat_inc(settle_q) : '0;

    // Decision taken in RUN. A real switch request has priority over a
    // simultaneous lock loss.
    start_d  = 1'b0;
    target_d = sel_req_i;
    err_d    = 1'b0;
    if (sel_valid_i && (32'(sel_req_i) >= 32'(NUM_SRC))) begin
      err_d = 1'b1;
    end else if (sel_valid_i && (sel_req_i != sel_active_q)) begin
      start_d = 1'b1;
    end
`ifdef CLK_SRC_LOCK_FALLBACK_EN
    else if (!lk_active) begin
      start_d  = 1'b1;
      target_d = DEF_SEL;
      err_d    = 1'b1;
    end
`endif
  end

  always_ff @(posedge sys_clock_i) begin
    if (reset_i) begin
      state_q      <= ST_RUN;
      target_q     <= DEF_SEL;
      cnt_q        <= '0;
      settle_q     <= '0;
      clk_en_q     <= onehot(DEF_SEL);
      sel_active_q <= DEF_SEL;
      locked_q     <= 1'b0;
      cpu_reset_q  <= 1'b1;
      switch_err_q <= 1'b0;
    end else begin
      switch_err_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          switch_err_q <= err_d;
          if (start_d) begin
            target_q    <= target_d;
            clk_en_q    <= '0;
            locked_q    <= 1'b0;
            cpu_reset_q <= 1'b1;
            cnt_q       <= '0;
            settle_q    <= '0;
            state_q     <= ST_GATE;
          end else begin
            locked_q    <= lk_active;
            cpu_reset_q <= ~lk_active;
          end
        end

        ST_GATE: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_WAIT_LOCK;
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end

        ST_WAIT_LOCK: begin
          settle_q <= settle_d;
          if (settle_d == SETTLE_TGT) begin
            state_q <= ST_ENABLE;
          end else if (cnt_q == TMO_LAST) begin
            // Target never qualified: fall back to the always-locked default.
            target_q     <= DEF_SEL;
            switch_err_q <= 1'b1;
            state_q      <= ST_ENABLE;
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end

        ST_ENABLE: begin
          // locked/cpu_reset are refreshed by the first RUN cycle after this.
          clk_en_q     <= onehot(target_q);
          sel_active_q <= target_q;
          state_q      <= ST_RUN;
        end

        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign sel_ready_o  = (state_q == ST_RUN);
  assign clk_en_o     = clk_en_q;
  assign sel_active_o = sel_active_q;
  assign locked_o     = locked_q;
  assign cpu_reset_o  = cpu_reset_q;
  assign switch_err_o = switch_err_q;

endmodule

// File: tb/tb_clk_src_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_src_ctrl
//
// Self-checking bench for clk_src_ctrl with shortened settle/timeout windows.
// Expected switch events (error pulse, gating, enabling) are queued with the
// cycle they must appear in when stimulus is driven; a monitor records the
// events the DUT actually produces and each test pops and compares both.
// Cycle numbering: cyc counts posedges; an input driven while cyc == n is
// sampled on edge n+1 and its registered effect is visible at cyc n+1.
// -----------------------------------------------------------------------------
module tb_clk_src_ctrl;

  localparam int NUM_SRC = 4;
  localparam int SEL_W   = 3;
  localparam int GAP     = 8;
  localparam int SETTLE  = 32;
  localparam int TIMEOUT = 256;

  logic               clk;
  logic               rst;
  logic [SEL_W-1:0]   sel_req;
  logic               sel_valid;
  logic               sel_ready;
  logic [NUM_SRC-1:0] src_locked;
  logic [NUM_SRC-1:0] clk_en;
  logic [SEL_W-1:0]   sel_active;
  logic               locked;
  logic               cpu_reset;
  logic               switch_err;

  clk_src_ctrl #(
    .NUM_SRC        (NUM_SRC),
    .SEL_W          (SEL_W),
    .DEFAULT_SRC    (0),
    .ALWAYS_LOCKED  (4'b0001),
    .GAP_CYCLES     (GAP),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .sys_clock_i  (clk),
    .reset_i      (rst),
    .sel_req_i    (sel_req),
    .sel_valid_i  (sel_valid),
    .sel_ready_o  (sel_ready),
    .src_locked_i (src_locked),
    .clk_en_o     (clk_en),
    .sel_active_o (sel_active),
    .locked_o     (locked),
    .cpu_reset_o  (cpu_reset),
    .switch_err_o (switch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum logic [1:0] {EV_ERR, EV_GATE, EV_EN} ev_kind_e;
  typedef struct packed {
    ev_kind_e           kind;
    logic [NUM_SRC-1:0] en;
    logic [SEL_W-1:0]   sel;
    logic [31:0]        cyc;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         obs_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  logic [NUM_SRC-1:0] prev_en;
  logic [10:0] st;

  assign st = {clk_en, sel_active, sel_ready, locked, cpu_reset, switch_err};

  function automatic ev_t mk_ev(input ev_kind_e k, input logic [3:0] en,
                                input logic [2:0] sel, input int unsigned c);
    ev_t e;
    e.kind = k;
    e.en   = en;
    e.sel  = sel;
    e.cyc  = 32'(c);
    return e;
  endfunction

  function automatic string ev_str(input ev_t e);
    return $sformatf("%s en=%b sel=%0d cyc=%0d", e.kind.name(), e.en, e.sel, e.cyc);
  endfunction

  function automatic logic [10:0] exp_st(input logic [3:0] en, input logic [2:0] sel,
                                         input logic rdy, input logic lk,
                                         input logic cr, input logic er);
    return {en, sel, rdy, lk, cr, er};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor: records what the DUT does, mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_en <= clk_en;
    end else begin
      if (switch_err === 1'b1) obs_q.push_back(mk_ev(EV_ERR, clk_en, sel_active, cyc));
      if (clk_en !== prev_en) begin
        obs_q.push_back(mk_ev((clk_en == '0) ? EV_GATE : EV_EN, clk_en, sel_active, cyc));
      end
      prev_en <= clk_en;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_obs(input int budget);
    for (int i = 0; i < budget && obs_q.size() < exp_q.size(); i++) step();
  endtask

  task automatic test_reset();
    logic [10:0] e_st;
    rst = 1'b1;
    repeat (3) step();
    exp_q.delete();
    obs_q.delete();
    e_st = exp_st(4'b0001, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (st !== e_st) begin n_fail++; $display("FAIL reset_hold: got %b required %b", st, e_st); end
    rst = 1'b0;
    n_checks++;
    if (st !== e_st) begin n_fail++; $display("FAIL reset_first_cycle: got %b required %b", st, e_st); end
    step();
    e_st = exp_st(4'b0001, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (st !== e_st) begin n_fail++; $display("FAIL reset_second_cycle: got %b required %b", st, e_st); end
  endtask

  task automatic test_switch();
    logic [10:0] e_st;
    ev_t e, o;
    int unsigned a, en_c;
    src_locked[2] = 1'b1;
    sel_req = 3'd2; sel_valid = 1'b1;
    a = cyc + 1;
    en_c = a + GAP + SETTLE + 1;
    exp_q.push_back(mk_ev(EV_GATE, 4'b0000, 3'd0, a));
    exp_q.push_back(mk_ev(EV_EN, 4'b0100, 3'd2, en_c));
    step();
    sel_valid = 1'b0;
    e_st = exp_st(4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (st !== e_st) begin n_fail++; $display("FAIL switch_gate_status: got %b required %b", st, e_st); end
    // A request while gating must be ignored.
    sel_req = 3'd1; sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    while (cyc < en_c) step();
    e_st = exp_st(4'b0100, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (st !== e_st) begin n_fail++; $display("FAIL switch_enable_status: got %b required %b", st, e_st); end
    step();
    e_st = exp_st(4'b0100, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (st !== e_st) begin n_fail++; $display("FAIL switch_locked_status: got %b required %b", st, e_st); end
    wait_obs(20);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL switch_events: no DUT event, required %s", ev_str(e));
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL switch_events: got %s, required %s", ev_str(o), ev_str(e)); end
      end
    end
  endtask

  task automatic test_reject_noop();
    logic [10:0] e_st;
    ev_t e, o;
    int unsigned a;
    sel_req = 3'd5; sel_valid = 1'b1;
    a = cyc + 1;
    exp_q.push_back(mk_ev(EV_ERR, 4'b0100, 3'd2, a));
    step();
    sel_valid = 1'b0;
    e_st = exp_st(4'b0100, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (st !== e_st) begin n_fail++; $display("FAIL reject_pulse: got %b required %b", st, e_st); end
    step();
    e_st = exp_st(4'b0100, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (st !== e_st) begin n_fail++; $display("FAIL reject_after: got %b required %b", st, e_st); end
    // Request for the already-active source: accepted, nothing happens.
    sel_req = 3'd2; sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    repeat (3) step();
    n_checks++;
    if (st !== e_st) begin n_fail++; $display("FAIL noop_status: got %b required %b", st, e_st); end
    wait_obs(5);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL reject_events: no DUT event, required %s", ev_str(e));
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL reject_events: got %s, required %s", ev_str(o), ev_str(e)); end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL noop_events: got %0d extra events, required 0", obs_q.size()); end
  endtask

  task automatic test_lock_loss();
    logic [10:0] e_st;
    ev_t e, o;
    int unsigned d;
    src_locked[2] = 1'b0;
    d = cyc + 3;
`ifdef CLK_SRC_LOCK_FALLBACK_EN
    exp_q.push_back(mk_ev(EV_ERR, 4'b0000, 3'd2, d));
    exp_q.push_back(mk_ev(EV_GATE, 4'b0000, 3'd2, d));
    exp_q.push_back(mk_ev(EV_EN, 4'b0001, 3'd0, d + GAP + SETTLE + 1));
`endif
    step(); step();
    e_st = exp_st(4'b0100, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (st !== e_st) begin n_fail++; $display("FAIL lockloss_sync_delay: got %b required %b", st, e_st); end
    step();
`ifdef CLK_SRC_LOCK_FALLBACK_EN
    e_st = exp_st(4'b0000, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (st !== e_st) begin n_fail++; $display("FAIL lockloss_fallback_start: got %b required %b", st, e_st); end
    wait_obs(GAP + SETTLE + 20);
    src_locked[2] = 1'b1;
    e_st = exp_st(4'b0001, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (st !== e_st) begin n_fail++; $display("FAIL lockloss_fallback_done: got %b required %b", st, e_st); end
`else
    e_st = exp_st(4'b0100, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (st !== e_st) begin n_fail++; $display("FAIL lockloss_drop: got %b required %b", st, e_st); end
    repeat (5) step();
    n_checks++;
    if (st !== e_st) begin n_fail++; $display("FAIL lockloss_hold: got %b required %b", st, e_st); end
    src_locked[2] = 1'b1;
    step(); step();
    n_checks++;
    if (st !== e_st) begin n_fail++; $display("FAIL lockloss_return_delay: got %b required %b", st, e_st); end
    step();
    e_st = exp_st(4'b0100, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (st !== e_st) begin n_fail++; $display("FAIL lockloss_recover: got %b required %b", st, e_st); end
`endif
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL lockloss_events: no DUT event, required %s", ev_str(e));
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL lockloss_events: got %s, required %s", ev_str(o), ev_str(e)); end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL lockloss_extra: got %0d extra events, required 0", obs_q.size()); end
  endtask

  task automatic test_timeout(input logic [2:0] act);
    logic [10:0] e_st;
    ev_t e, o;
    int unsigned a;
    src_locked[3] = 1'b0;
    sel_req = 3'd3; sel_valid = 1'b1;
    a = cyc + 1;
    exp_q.push_back(mk_ev(EV_GATE, 4'b0000, act, a));
    exp_q.push_back(mk_ev(EV_ERR, 4'b0000, act, a + GAP + TIMEOUT));
    exp_q.push_back(mk_ev(EV_EN, 4'b0001, 3'd0, a + GAP + TIMEOUT + 1));
    step();
    sel_valid = 1'b0;
    wait_obs(GAP + TIMEOUT + 20);
    e_st = exp_st(4'b0001, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (st !== e_st) begin n_fail++; $display("FAIL timeout_status: got %b required %b", st, e_st); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL timeout_events: no DUT event, required %s", ev_str(e));
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL timeout_events: got %s, required %s", ev_str(o), ev_str(e)); end
      end
    end
  endtask

  task automatic test_glitch();
    logic [10:0] e_st;
    ev_t e, o;
    int unsigned a, m;
    src_locked[3] = 1'b1;
    sel_req = 3'd3; sel_valid = 1'b1;
    a = cyc + 1;
    // Glitch lands when the settle count has reached 16.
    m = a + GAP + 14;
    exp_q.push_back(mk_ev(EV_GATE, 4'b0000, 3'd0, a));
    exp_q.push_back(mk_ev(EV_EN, 4'b1000, 3'd3, m + 4 + SETTLE));
    step();
    sel_valid = 1'b0;
    while (cyc < m) step();
    src_locked[3] = 1'b0;
    step();
    src_locked[3] = 1'b1;
    wait_obs(SETTLE + 20);
    e_st = exp_st(4'b1000, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (st !== e_st) begin n_fail++; $display("FAIL glitch_status: got %b required %b", st, e_st); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL glitch_events: no DUT event, required %s", ev_str(e));
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL glitch_events: got %s, required %s", ev_str(o), ev_str(e)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] e_st;
    ev_t e, o;
    sel_req = 3'd2; sel_valid = 1'b1;
    exp_q.push_back(mk_ev(EV_GATE, 4'b0000, 3'd3, cyc + 1));
    step();
    sel_valid = 1'b0;
    wait_obs(5);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL midreset_events: no DUT event, required %s", ev_str(e));
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL midreset_events: got %s, required %s", ev_str(o), ev_str(e)); end
      end
    end
    repeat (GAP + 4) step();
    rst = 1'b1;
    step();
    e_st = exp_st(4'b0001, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (st !== e_st) begin n_fail++; $display("FAIL midreset_values: got %b required %b", st, e_st); end
    step();
    rst = 1'b0;
    step();
    e_st = exp_st(4'b0001, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (st !== e_st) begin n_fail++; $display("FAIL midreset_recover: got %b required %b", st, e_st); end
    repeat (3) step();
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("FAIL midreset_extra: got %0d extra events, required 0", obs_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    sel_req    = '0;
    sel_valid  = 1'b0;
    src_locked = '0;
    test_reset();
    test_switch();
    test_reject_noop();
    test_lock_loss();
`ifdef CLK_SRC_LOCK_FALLBACK_EN
    test_timeout(3'd0);
`else
    test_timeout(3'd2);
`endif
    test_glitch();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
